memory_stage: RTL and testbench
===============================

// Module: memory_stage
// PURPOSE
// Memory stage of the pipelined datapath; sits between the EX/MEM latch and the MEM/WB latch.
// Sequences one data-cache access per instruction (load, store, LL, SC) and holds the
// pipeline stalled until the cache answers. Presents the loaded word / SC result as dload.
// Owns the LL/SC link register, including invalidation by coherence snoops.
// PARAMETERS
// ADDR_W     32  byte-address width; link compare uses bits [ADDR_W-1:2]
// CNT_W      16  width of the saturating stall-cycle performance counter
// PORTS
// CLK          in   1       clock, rising edge
// nRST         in   1       reset, asynchronous, active-low
// ex_valid     in   1       EX/MEM latch holds a live instruction
// MemRead      in   1       load (LW or LL)
// MemWrite     in   1       store (SW or SC)
// LL           in   1       load-linked qualifier (with MemRead)
// SC           in   1       store-conditional qualifier (with MemWrite)
// flush        in   1       squash the instruction currently in this stage
// addr         in   ADDR_W  effective address from ALU
// store_data   in   32      rt value to store
// dhit         in   1       cache completes the current request this cycle
// dmemload     in   32      cache read data, valid when dhit
// inv_valid    in   1       snoop invalidation this cycle
// inv_addr     in   ADDR_W  invalidated address
// dmemREN      out  1       cache read request
// dmemWEN      out  1       cache write request
// dmemaddr     out  ADDR_W  cache address
// dmemstore    out  32      cache write data
// dload        out  32      load data / SC result (1 = success, 0 = fail) for MEM/WB
// mem_stall    out  1       1 = hold PC, IF/ID, ID/EX, EX/MEM latches; MEM/WB en = !mem_stall
// stall_cnt    out  CNT_W   cycles with mem_stall = 1 since reset, saturating
// BEHAVIOUR
// Reset: state IDLE; dmemREN = dmemWEN = 0; dmemaddr = dmemstore = dload = 0; link_valid = 0,
//   link_addr = 0; stall_cnt = 0; mem_stall = 0.
// start = ex_valid & !flush & (MemRead | MemWrite). sc_ok = link_valid & (link_addr == addr[ADDR_W-1:2]),
//   evaluated in IDLE after applying same-cycle inv_valid (a coincident matching snoop makes sc_ok = 0).
// FSM states IDLE, ACCESS, DONE:
//  IDLE:   start & (MemRead | (MemWrite & (!SC | sc_ok))) -> ACCESS; register addr, store_data, op bits.
//          start & SC & !sc_ok -> DONE, dload <= 0, no cache request issued.
//          !start -> stay; mem_stall = 0.
//  ACCESS: dmemREN = registered MemRead, dmemWEN = registered MemWrite, both held stable until dhit.
//          dhit -> DONE; loads: dload <= dmemload; SC: dload <= 1; SW: dload unchanged.
//          flush ignored in ACCESS (the access always completes).
//  DONE:   requests low; mem_stall = 0 for exactly this cycle, so MEM/WB captures dload; -> IDLE.
// mem_stall = (IDLE & start) | ACCESS. Latency: hit on first ACCESS cycle -> 2 stall cycles, then DONE.
// Back-to-back memory ops: the next op is seen in IDLE the cycle after DONE (min 3 cycles each).
// Link register: LL completing with dhit -> link_valid <= 1, link_addr <= addr[ADDR_W-1:2].
//   Any SC leaving IDLE (success or fail) -> link_valid <= 0.
//   inv_valid & inv_addr[ADDR_W-1:2] == link_addr -> link_valid <= 0 (any state).
//   LL set and snoop clear in the same cycle: set wins (snoop precedes the LL).
// Non-memory instruction: no state change, dload holds its last value.
// stall_cnt: +1 per cycle with mem_stall = 1; holds at all-ones.
// nRST low mid-ACCESS: requests drop immediately (async); no completion is reported.
// TESTING
// LW 0x40, dhit after 3 ACCESS cycles, dmemload=0xDEADBEEF -> dmemREN 3 cyc, mem_stall 4 cyc, dload=0xDEADBEEF in DONE.
// SW 0x80 data 0x1234, dhit first cycle -> dmemWEN=1 one cycle, dmemaddr=0x80, dmemstore=0x1234, stall_cnt=2.
// LL 0x100 then SC 0x100 -> SC issues WEN, dload=1; second SC 0x100 -> no WEN, dload=0.
// LL 0x100, inv_valid inv_addr=0x102 -> SC 0x100 fails (dload=0, no WEN); inv 0x104 instead -> SC succeeds.
// flush with start in IDLE -> no request, mem_stall=0; flush during ACCESS -> access completes normally.
// nRST pulse during ACCESS -> REN/WEN=0, dload=0, link_valid=0, stall_cnt=0, state IDLE.

Source files
------------

// File: rtl/memory_stage_if.sv
// Data-cache port of the memory stage: request/response handshake plus coherence snoop.
interface memory_stage_if #(
    parameter int unsigned ADDR_W = 32
) ();
    logic              dmemREN;
    logic              dmemWEN;
    logic [ADDR_W-1:0] dmemaddr;
    logic [31:0]       dmemstore;
    logic              dhit;
    logic [31:0]       dmemload;
    logic              inv_valid;
    logic [ADDR_W-1:0] inv_addr;

    modport master (
        output dmemREN, dmemWEN, dmemaddr, dmemstore,
        input  dhit, dmemload, inv_valid, inv_addr
    );

    modport slave (
        input  dmemREN, dmemWEN, dmemaddr, dmemstore,
        output dhit, dmemload, inv_valid, inv_addr
    );
endinterface

// File: rtl/memory_stage.sv
// Pipeline memory stage: one data-cache access per load/store/LL/SC, stalls until dhit,
// owns the LL/SC link register and a saturating stall-cycle counter.
module memory_stage #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ex_valid,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              LL,
    input  logic              SC,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       store_data,
    memory_stage_if.master    dc,
    output logic [31:0]       dload,
    output logic              mem_stall,
    output logic [CNT_W-1:0]  stall_cnt
);
    localparam int unsigned WORD_W = ADDR_W - 2;
    localparam int unsigned DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                ren_q, ren_d;
    logic                wen_q, wen_d;
    logic                ll_q, ll_d;
    logic                sc_q, sc_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic [DATA_W-1:0]   dload_q, dload_d;
    logic                link_valid_q, link_valid_d;
    logic [WORD_W-1:0]   link_addr_q, link_addr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    logic start_c;
    logic sc_op_c;
    logic snoop_hit_c;
    logic sc_ok_c;
    logic go_access_c;

    // Decode; a coincident matching snoop already kills the link for this SC.
    always_comb begin
        start_c     = ex_valid & ~flush & (MemRead | MemWrite);
        sc_op_c     = MemWrite & SC;
        snoop_hit_c = dc.inv_valid & (dc.inv_addr[ADDR_W-1:2] == link_addr_q);
        sc_ok_c     = link_valid_q & ~snoop_hit_c & (link_addr_q == addr[ADDR_W-1:2]);
        go_access_c = start_c & (MemRead | ~sc_op_c | sc_ok_c);
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (go_access_c) begin
                    state_d = ACCESS;
                end else if (start_c) begin
                    state_d = DONE;
                end
            end
            ACCESS: begin
                if (dc.dhit) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_stall    = ((state_q == IDLE) & start_c) | (state_q == ACCESS);
        dc.dmemREN   = ren_q;
        dc.dmemWEN   = wen_q;
        dc.dmemaddr  = addr_q;
        dc.dmemstore = data_q;
        dload        = dload_q;
        stall_cnt    = cnt_q;
    end

    // Request capture, load/SC result and link register update.
    always_comb begin
        ren_d        = ren_q;
        wen_d        = wen_q;
        ll_d         = ll_q;
        sc_d         = sc_q;
        addr_d       = addr_q;
        data_d       = data_q;
        dload_d      = dload_q;
        link_valid_d = link_valid_q;
        link_addr_d  = link_addr_q;

        if (snoop_hit_c) begin
            link_valid_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (go_access_c) begin
                    ren_d  = MemRead;
                    wen_d  = MemWrite;
                    ll_d   = MemRead & LL;
                    sc_d   = sc_op_c;
                    addr_d = addr;
                    data_d = store_data;
                end else if (start_c) begin
                    dload_d = '0;
                end
                if (start_c & sc_op_c) begin
                    link_valid_d = 1'b0;
                end
            end
            ACCESS: begin
                if (dc.dhit) begin
                    ren_d = 1'b0;
                    wen_d = 1'b0;
                    if (ren_q) begin
                        dload_d = dc.dmemload;
                    end else if (sc_q) begin
                        dload_d = DATA_W'(1);
                    end
                    // LL completion overrides a same-cycle snoop.
                    if (ll_q) begin
                        link_valid_d = 1'b1;
                        link_addr_d  = addr_q[ADDR_W-1:2];
                    end
                end
            end
            default: ;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (mem_stall && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            ren_q        <= 1'b0;
            wen_q        <= 1'b0;
            ll_q         <= 1'b0;
            sc_q         <= 1'b0;
            addr_q       <= '0;
            data_q       <= '0;
            dload_q      <= '0;
            link_valid_q <= 1'b0;
            link_addr_q  <= '0;
            cnt_q        <= '0;
        end else begin
            ren_q        <= ren_d;
            wen_q        <= wen_d;
            ll_q         <= ll_d;
            sc_q         <= sc_d;
            addr_q       <= addr_d;
            data_q       <= data_d;
            dload_q      <= dload_d;
            link_valid_q <= link_valid_d;
            link_addr_q  <= link_addr_d;
            cnt_q        <= cnt_d;
        end
    end
endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: expected dload queued at issue, popped on the DONE cycle.
module tb_memory_stage;
    logic        CLK;
    logic        nRST;
    logic        ex_valid, MemRead, MemWrite, LL, SC, flush;
    logic [31:0] addr, store_data;
    logic [31:0] dload;
    logic        mem_stall;
    logic [15:0] stall_cnt;

    memory_stage_if #(.ADDR_W(32)) dc ();

    memory_stage #(.ADDR_W(32), .CNT_W(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .ex_valid   (ex_valid),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .LL         (LL),
        .SC         (SC),
        .flush      (flush),
        .addr       (addr),
        .store_data (store_data),
        .dc         (dc.master),
        .dload      (dload),
        .mem_stall  (mem_stall),
        .stall_cnt  (stall_cnt)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          exp_cnt  = 0;
    logic [31:0] exp_q[$];

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // One instruction held in EX/MEM until the stage reports DONE.
    task automatic run_op(input string tag, input bit rd, input bit wr, input bit ll, input bit sc,
                          input logic [31:0] a, input logic [31:0] d, input logic [31:0] ld,
                          input int hit_after, input int exp_ren, input int exp_wen,
                          input int exp_stall, input logic [31:0] exp_dload,
                          input int inv_cyc, input logic [31:0] inv_a, input int flush_from);
        int          stalls, rens, wens;
        bit          done;
        logic [31:0] exp_v;
        stalls = 0; rens = 0; wens = 0; done = 1'b0;
        @(negedge CLK);
        ex_valid = 1'b1; MemRead = rd; MemWrite = wr; LL = ll; SC = sc;
        addr = a; store_data = d;
        exp_q.push_back(exp_dload);
        exp_cnt += exp_stall;
        for (int cyc = 0; cyc < 40 && !done; cyc++) begin
            if (cyc > 0) @(negedge CLK);
            dc.dhit      = 1'b0;
            dc.inv_valid = (cyc == inv_cyc);
            dc.inv_addr  = inv_a;
            flush        = (flush_from >= 0) && (cyc >= flush_from);
            #1;
            if (cyc > 0 && !mem_stall && !dc.dmemREN && !dc.dmemWEN) begin
                done  = 1'b1;
                exp_v = exp_q.pop_front();
                chk({tag, "_dload"}, dload, exp_v);
                chk({tag, "_stall"}, 32'(stalls), 32'(exp_stall));
                chk({tag, "_ren"}, 32'(rens), 32'(exp_ren));
                chk({tag, "_wen"}, 32'(wens), 32'(exp_wen));
                chk({tag, "_cnt"}, 32'(stall_cnt), 32'(exp_cnt));
                ex_valid = 1'b0; flush = 1'b0; dc.inv_valid = 1'b0;
            end else begin
                if (mem_stall) stalls++;
                if (dc.dmemREN) rens++;
                if (dc.dmemWEN) wens++;
                if ((dc.dmemREN || dc.dmemWEN) && (rens + wens == 1)) begin
                    chk({tag, "_addr"}, dc.dmemaddr, a);
                    if (dc.dmemWEN) chk({tag, "_wdata"}, dc.dmemstore, d);
                end
                if ((dc.dmemREN || dc.dmemWEN) && (rens + wens == hit_after)) begin
                    dc.dhit     = 1'b1;
                    dc.dmemload = ld;
                end
            end
        end
        chk({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic snoop(input logic [31:0] a);
        @(negedge CLK);
        dc.inv_valid = 1'b1; dc.inv_addr = a;
        @(negedge CLK);
        dc.inv_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        nRST = 1'b0; ex_valid = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; LL = 1'b0; SC = 1'b0;
        flush = 1'b0; addr = '0; store_data = '0;
        dc.dhit = 1'b0; dc.dmemload = '0; dc.inv_valid = 1'b0; dc.inv_addr = '0;
        #2;
        chk("rst_ren", 32'(dc.dmemREN), 0);
        chk("rst_wen", 32'(dc.dmemWEN), 0);
        chk("rst_addr", dc.dmemaddr, 0);
        chk("rst_store", dc.dmemstore, 0);
        chk("rst_dload", dload, 0);
        chk("rst_stall", 32'(mem_stall), 0);
        chk("rst_cnt", 32'(stall_cnt), 0);
        @(negedge CLK);
        nRST = 1'b1;

        run_op("lw40", 1, 0, 0, 0, 32'h40, 0, 32'hDEADBEEF, 3, 3, 0, 4, 32'hDEADBEEF, -1, 0, -1);
        run_op("sw80", 0, 1, 0, 0, 32'h80, 32'h1234, 0, 1, 0, 1, 2, 32'hDEADBEEF, -1, 0, -1);
        run_op("ll100", 1, 0, 1, 0, 32'h100, 0, 32'hCAFE0001, 2, 2, 0, 3, 32'hCAFE0001, -1, 0, -1);
        run_op("sc_ok", 0, 1, 0, 1, 32'h100, 32'h5, 0, 1, 0, 1, 2, 32'd1, -1, 0, -1);
        run_op("sc_again", 0, 1, 0, 1, 32'h100, 32'h6, 0, 0, 0, 0, 1, 32'd0, -1, 0, -1);

        run_op("ll_a", 1, 0, 1, 0, 32'h100, 0, 32'h77, 1, 1, 0, 2, 32'h77, -1, 0, -1);
        snoop(32'h102);
        run_op("sc_snooped", 0, 1, 0, 1, 32'h100, 32'h7, 0, 0, 0, 0, 1, 32'd0, -1, 0, -1);
        run_op("ll_b", 1, 0, 1, 0, 32'h100, 0, 32'h88, 1, 1, 0, 2, 32'h88, -1, 0, -1);
        snoop(32'h104);
        run_op("sc_other", 0, 1, 0, 1, 32'h100, 32'h8, 0, 1, 0, 1, 2, 32'd1, -1, 0, -1);

        run_op("ll_c", 1, 0, 1, 0, 32'h100, 0, 32'h99, 1, 1, 0, 2, 32'h99, -1, 0, -1);
        run_op("sc_coinc", 0, 1, 0, 1, 32'h100, 32'h9, 0, 0, 0, 0, 1, 32'd0, 0, 32'h100, -1);
        run_op("ll_race", 1, 0, 1, 0, 32'h200, 0, 32'hAA, 1, 1, 0, 2, 32'hAA, 1, 32'h200, -1);
        run_op("sc_race", 0, 1, 0, 1, 32'h200, 32'hB, 0, 1, 0, 1, 2, 32'd1, -1, 0, -1);

        // Flush with start in IDLE: no request, no stall.
        @(negedge CLK);
        ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; LL = 1'b0; SC = 1'b0;
        addr = 32'h48; flush = 1'b1;
        #1 chk("flush_idle_stall", 32'(mem_stall), 0);
        @(negedge CLK);
        #1 chk("flush_idle_ren", 32'(dc.dmemREN), 0);
        chk("flush_idle_cnt", 32'(stall_cnt), 32'(exp_cnt));
        ex_valid = 1'b0; flush = 1'b0;

        run_op("flush_acc", 1, 0, 0, 0, 32'h44, 0, 32'h0BADF00D, 2, 2, 0, 3, 32'h0BADF00D, -1, 0, 1);

        // Non-memory instruction leaves dload alone.
        @(negedge CLK);
        ex_valid = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
        #1 chk("nonmem_stall", 32'(mem_stall), 0);
        @(negedge CLK);
        #1 chk("nonmem_dload", dload, 32'h0BADF00D);
        ex_valid = 1'b0;

        // Reset mid-ACCESS also drops the link set by this LL.
        run_op("ll300", 1, 0, 1, 0, 32'h300, 0, 32'h11, 1, 1, 0, 2, 32'h11, -1, 0, -1);
        @(negedge CLK);
        ex_valid = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; LL = 1'b0; SC = 1'b0; addr = 32'h40;
        @(negedge CLK);
        #1 chk("midrst_pre_ren", 32'(dc.dmemREN), 1);
        nRST = 1'b0;
        #1;
        chk("midrst_ren", 32'(dc.dmemREN), 0);
        chk("midrst_wen", 32'(dc.dmemWEN), 0);
        chk("midrst_dload", dload, 0);
        chk("midrst_cnt", 32'(stall_cnt), 0);
        ex_valid = 1'b0; MemRead = 1'b0;
        #1 chk("midrst_stall", 32'(mem_stall), 0);
        @(negedge CLK);
        nRST = 1'b1;
        exp_cnt = 0;
        run_op("sc_after_rst", 0, 1, 0, 1, 32'h300, 32'hC, 0, 0, 0, 0, 1, 32'd0, -1, 0, -1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
